// File: rtl/cache_bus_responder_pkg.sv
// Shared types and constants for the cache bus responder.
// Holds FSM encodings, common literals and the byte merge helper.
package cache_bus_responder_pkg;

  localparam logic        Valid     = 1'b1;
  localparam logic        Invalid   = 1'b0;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;
  localparam logic        RstEnable = 1'b1;

  localparam int unsigned RdLatencyDef = 2;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_WAIT  = 2'd1,
    R_BURST = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_word,
    input logic [31:0] new_word,
    input logic [3:0]  sel
  );
    logic [31:0] res;
    res = old_word;
    for (int k = 0; k < 4; k++) begin
      if (sel[k]) res[8*k +: 8] = new_word[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/responder_ram.sv
// Word-wide backing store: combinational read, byte-enabled write.
// Contents are deliberately not reset so they survive a bus reset.
module responder_ram
  import cache_bus_responder_pkg::*;
#(
  parameter int unsigned WORDS = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    sel,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  assign rdata = mem[raddr];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= merge_bytes(mem[waddr], wdata, sel);
  end

endmodule

// File: rtl/cache_bus_responder.sv
// Bus slave with independent read and write burst engines
// sharing one word-addressed backing store.
module cache_bus_responder
  import cache_bus_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned RD_LATENCY = RdLatencyDef
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_ce_i,
  input  logic [3:0]  bus_sel_i,
  input  logic        bus_ren_i,
  input  logic [31:0] bus_raddr_i,
  input  logic [3:0]  bus_rlen_i,
  input  logic        bus_rready_i,
  output logic [31:0] bus_rdata_o,
  output logic        bus_rvalid_o,
  input  logic        bus_wen_i,
  input  logic [31:0] bus_waddr_i,
  input  logic [3:0]  bus_wlen_i,
  input  logic [31:0] bus_wdata_i,
  input  logic        bus_wvalid_i,
  input  logic        bus_wlast_i,
  output logic        bus_bvalid_o,
  output logic        protocol_err_o
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam logic [3:0] LatLoad = 4'(RD_LATENCY - 1);

  rd_state_e     r_state, r_state_d;
  logic [AW-1:0] r_idx, r_idx_d;
  logic [3:0]    r_len, r_len_d;
  logic [3:0]    r_cnt, r_cnt_d;
  logic [3:0]    r_lat, r_lat_d;

  wr_state_e     w_state, w_state_d;
  logic [AW-1:0] w_idx, w_idx_d;
  logic [3:0]    w_len, w_len_d;
  logic [3:0]    w_cnt, w_cnt_d;
  logic          err, err_d;

  logic [31:0]   ram_rdata;
  logic          ram_we;
  logic          len_hit;
  logic          unused;

  assign unused = ^{bus_raddr_i[31:AW+2], bus_raddr_i[1:0],
                    bus_waddr_i[31:AW+2], bus_waddr_i[1:0]};

  responder_ram #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .sel   (bus_sel_i),
    .waddr (w_idx),
    .wdata (bus_wdata_i),
    .raddr (r_idx),
    .rdata (ram_rdata)
  );

  always_comb begin
    r_state_d    = r_state;
    r_idx_d      = r_idx;
    r_len_d      = r_len;
    r_cnt_d      = r_cnt;
    r_lat_d      = r_lat;
    bus_rvalid_o = Invalid;
    bus_rdata_o  = ZeroWord;
    unique case (r_state)
      R_IDLE: begin
        if (bus_ce_i && bus_ren_i) begin
          r_state_d = R_WAIT;
          r_idx_d   = bus_raddr_i[AW+1:2];
          r_len_d   = bus_rlen_i;
          r_cnt_d   = '0;
          r_lat_d   = LatLoad;
        end
      end
      R_WAIT: begin
        if (r_lat == '0) r_state_d = R_BURST;
        else             r_lat_d   = r_lat - 4'd1;
      end
      R_BURST: begin
        bus_rvalid_o = Valid;
        bus_rdata_o  = ram_rdata;
        if (bus_rready_i) begin
          r_idx_d = r_idx + 1'b1;
          r_cnt_d = r_cnt + 4'd1;
          if (r_cnt == r_len) begin
            r_state_d = R_IDLE;
            r_cnt_d   = '0;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign len_hit = (w_cnt == w_len);

  // The write lands at the edge, so a same-cycle read beat sees old data.
  always_comb begin
    w_state_d    = w_state;
    w_idx_d      = w_idx;
    w_len_d      = w_len;
    w_cnt_d      = w_cnt;
    err_d        = err;
    ram_we       = Invalid;
    bus_bvalid_o = Invalid;
    unique case (w_state)
      W_IDLE: begin
        if (bus_ce_i && bus_wen_i) begin
          w_state_d = W_DATA;
          w_idx_d   = bus_waddr_i[AW+1:2];
          w_len_d   = bus_wlen_i;
          w_cnt_d   = '0;
        end
      end
      W_DATA: begin
        if (bus_wvalid_i) begin
          ram_we  = (rst != RstEnable);
          w_idx_d = w_idx + 1'b1;
          w_cnt_d = w_cnt + 4'd1;
          if (len_hit || bus_wlast_i) begin
            w_state_d = W_RESP;
            w_cnt_d   = '0;
            if (len_hit != bus_wlast_i) err_d = Valid;
          end
        end
      end
      W_RESP: begin
        bus_bvalid_o = Valid;
        w_state_d    = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state <= R_IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_lat   <= '0;
      w_state <= W_IDLE;
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      err     <= Invalid;
    end else begin
      r_state <= r_state_d;
      r_idx   <= r_idx_d;
      r_len   <= r_len_d;
      r_cnt   <= r_cnt_d;
      r_lat   <= r_lat_d;
      w_state <= w_state_d;
      w_idx   <= w_idx_d;
      w_len   <= w_len_d;
      w_cnt   <= w_cnt_d;
      err     <= err_d;
    end
  end

  assign protocol_err_o = err;

endmodule

// File: tb/tb_cache_bus_responder.sv
// Bench for cache_bus_responder: write/read vector tables,
// read-data scoreboard and hand-built overlap/reset sequences.
module tb_cache_bus_responder;

  localparam int MW  = 16;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_ce_i;
  logic [3:0]  bus_sel_i;
  logic        bus_ren_i;
  logic [31:0] bus_raddr_i;
  logic [3:0]  bus_rlen_i;
  logic        bus_rready_i;
  logic [31:0] bus_rdata_o;
  logic        bus_rvalid_o;
  logic        bus_wen_i;
  logic [31:0] bus_waddr_i;
  logic [3:0]  bus_wlen_i;
  logic [31:0] bus_wdata_i;
  logic        bus_wvalid_i;
  logic        bus_wlast_i;
  logic        bus_bvalid_o;
  logic        protocol_err_o;

  always #5 clk = ~clk;

  cache_bus_responder #(
    .MEM_WORDS  (MW),
    .RD_LATENCY (LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus_ce_i       (bus_ce_i),
    .bus_sel_i      (bus_sel_i),
    .bus_ren_i      (bus_ren_i),
    .bus_raddr_i    (bus_raddr_i),
    .bus_rlen_i     (bus_rlen_i),
    .bus_rready_i   (bus_rready_i),
    .bus_rdata_o    (bus_rdata_o),
    .bus_rvalid_o   (bus_rvalid_o),
    .bus_wen_i      (bus_wen_i),
    .bus_waddr_i    (bus_waddr_i),
    .bus_wlen_i     (bus_wlen_i),
    .bus_wdata_i    (bus_wdata_i),
    .bus_wvalid_i   (bus_wvalid_i),
    .bus_wlast_i    (bus_wlast_i),
    .bus_bvalid_o   (bus_bvalid_o),
    .protocol_err_o (protocol_err_o)
  );

  typedef struct {
    logic [31:0] addr;
    int          len;
    logic [3:0]  sel;
    int          last_at;
    logic [31:0] data;
    logic        exp_err;
  } wr_vec_t;

  typedef struct {
    logic [31:0] addr;
    int          len;
    int          mode;
    logic [31:0] exp_first;
  } rd_vec_t;

  int          passed = 0;
  int          total  = 0;
  logic [31:0] model [MW];
  logic [31:0] sbq [$];
  wr_vec_t     wv [5];
  rd_vec_t     rv [6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus_rvalid_o) begin
        if (sbq.size() == 0) begin
          chk("rd_unexpected_beat", 32'd1, 32'd0);
        end else begin
          chk("rd_beat_data", bus_rdata_o, sbq[0]);
          if (bus_rready_i) void'(sbq.pop_front());
        end
      end else begin
        chk("rd_data_zero_idle", bus_rdata_o, 32'h0);
      end
    end
  end

  task automatic do_write(input logic [31:0] addr, input int len,
                          input logic [3:0] sel, input int last_at,
                          input logic [31:0] data, input logic exp_err);
    int b;
    int i;
    logic [31:0] d;
    bus_ce_i    = 1'b1;
    bus_wen_i   = 1'b1;
    bus_waddr_i = addr;
    bus_wlen_i  = 4'(len);
    bus_sel_i   = sel;
    cyc();
    bus_wen_i = 1'b0;
    bus_ce_i  = 1'b0;
    b = 0;
    while (1) begin
      d = data + 32'(b);
      i = (int'(addr >> 2) + b) % MW;
      bus_wvalid_i = 1'b1;
      bus_wdata_i  = d;
      bus_wlast_i  = (b == last_at);
      for (int k = 0; k < 4; k++)
        if (sel[k]) model[i][8*k +: 8] = d[8*k +: 8];
      cyc();
      if (b == len || b == last_at) break;
      b++;
    end
    bus_wvalid_i = 1'b0;
    bus_wlast_i  = 1'b0;
    chk("wr_bvalid_pulse", 32'(bus_bvalid_o), 32'd1);
    chk("wr_protocol_err", 32'(protocol_err_o), 32'(exp_err));
    cyc();
    chk("wr_bvalid_low", 32'(bus_bvalid_o), 32'd0);
    bus_ce_i = 1'b1;
  endtask

  task automatic do_read(input logic [31:0] addr, input int len,
                         input int mode, input logic [31:0] exp_first);
    int idx;
    int cycn;
    int first;
    int beats;
    logic tg;
    logic rdy;
    idx = int'(addr >> 2) % MW;
    for (int b = 0; b <= len; b++) sbq.push_back(model[(idx + b) % MW]);
    bus_ce_i     = 1'b1;
    bus_ren_i    = 1'b1;
    bus_raddr_i  = addr;
    bus_rlen_i   = 4'(len);
    bus_rready_i = 1'b0;
    cyc();
    bus_ce_i    = (mode != 1);
    bus_raddr_i = 32'hFFFF_FFF0;
    bus_rlen_i  = 4'hF;
    cycn  = 1;
    first = -1;
    beats = 0;
    tg    = 1'b1;
    while (beats <= len && cycn < 200) begin
      if (bus_rvalid_o) begin
        bus_ren_i = 1'b0;
        if (first < 0) begin
          first = cycn;
          chk("rd_first_word", bus_rdata_o, exp_first);
        end
        case (mode)
          0: rdy = 1'b1;
          1: begin rdy = tg; tg = ~tg; end
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        bus_rready_i = rdy;
        if (rdy) beats++;
      end else begin
        bus_rready_i = 1'b0;
      end
      cyc();
      cycn++;
    end
    bus_rready_i = 1'b0;
    bus_ren_i    = 1'b0;
    chk("rd_burst_done", 32'(beats > len), 32'd1);
    chk("rd_latency", 32'(first), 32'(1 + LAT));
    chk("rd_rvalid_end", 32'(bus_rvalid_o), 32'd0);
    chk("rd_sb_empty", 32'(sbq.size()), 32'd0);
    bus_ce_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] old;
    int n;
    rst          = 1'b1;
    bus_ce_i     = 1'b0;
    bus_sel_i    = 4'h0;
    bus_ren_i    = 1'b0;
    bus_raddr_i  = 32'h0;
    bus_rlen_i   = 4'h0;
    bus_rready_i = 1'b0;
    bus_wen_i    = 1'b0;
    bus_waddr_i  = 32'h0;
    bus_wlen_i   = 4'h0;
    bus_wdata_i  = 32'h0;
    bus_wvalid_i = 1'b0;
    bus_wlast_i  = 1'b0;

    wv[0] = '{32'h10, 0, 4'hF, 0, 32'h1122_3344, 1'b0};
    wv[1] = '{32'h10, 0, 4'h3, 0, 32'hAABB_CCDD, 1'b0};
    wv[2] = '{32'h3C, 1, 4'hF, 1, 32'h2000_0000, 1'b0};
    wv[3] = '{32'h20, 2, 4'hC, 2, 32'h5566_0000, 1'b0};
    wv[4] = '{32'h04, 3, 4'hF, 2, 32'h3000_0000, 1'b1};

    rv[0] = '{32'h10, 0, 0, 32'h1122_CCDD};
    rv[1] = '{32'h20, 7, 1, 32'h5566_0008};
    rv[2] = '{32'h3C, 1, 0, 32'h2000_0000};
    rv[3] = '{32'h13, 0, 2, 32'h1122_CCDD};
    rv[4] = '{32'h08, 3, 2, 32'h3000_0001};
    rv[5] = '{32'h30, 15, 1, 32'h1000_000C};

    repeat (3) cyc();
    chk("reset_rvalid", 32'(bus_rvalid_o), 32'd0);
    chk("reset_rdata", bus_rdata_o, 32'h0);
    chk("reset_bvalid", 32'(bus_bvalid_o), 32'd0);
    chk("reset_err", 32'(protocol_err_o), 32'd0);
    rst      = 1'b0;
    bus_ce_i = 1'b1;
    cyc();

    do_write(32'h0, 15, 4'hF, 15, 32'h1000_0000, 1'b0);
    for (int v = 0; v < 5; v++)
      do_write(wv[v].addr, wv[v].len, wv[v].sel, wv[v].last_at,
               wv[v].data, wv[v].exp_err);
    for (int v = 0; v < 6; v++)
      do_read(rv[v].addr, rv[v].len, rv[v].mode, rv[v].exp_first);
    chk("err_sticky", 32'(protocol_err_o), 32'd1);

    // read beat of word 5 coincides with a write beat to word 5
    old = model[5];
    bus_ce_i     = 1'b1;
    bus_ren_i    = 1'b1;
    bus_raddr_i  = 32'h14;
    bus_rlen_i   = 4'h0;
    bus_rready_i = 1'b1;
    sbq.push_back(old);
    cyc();
    bus_ren_i = 1'b0;
    cyc();
    bus_wen_i   = 1'b1;
    bus_waddr_i = 32'h14;
    bus_wlen_i  = 4'h0;
    bus_sel_i   = 4'hF;
    cyc();
    bus_wen_i    = 1'b0;
    bus_wvalid_i = 1'b1;
    bus_wdata_i  = 32'hCAFE_F00D;
    bus_wlast_i  = 1'b1;
    chk("overlap_rvalid", 32'(bus_rvalid_o), 32'd1);
    chk("overlap_old_data", bus_rdata_o, old);
    cyc();
    model[5]     = 32'hCAFE_F00D;
    bus_wvalid_i = 1'b0;
    bus_wlast_i  = 1'b0;
    chk("overlap_bvalid", 32'(bus_bvalid_o), 32'd1);
    chk("overlap_rvalid_end", 32'(bus_rvalid_o), 32'd0);
    bus_rready_i = 1'b0;
    cyc();
    do_read(32'h14, 0, 0, 32'hCAFE_F00D);

    // requests with chip enable low must be ignored
    bus_ce_i     = 1'b0;
    bus_ren_i    = 1'b1;
    bus_raddr_i  = 32'h0;
    bus_wen_i    = 1'b1;
    bus_waddr_i  = 32'h4;
    bus_wlen_i   = 4'h0;
    bus_wvalid_i = 1'b1;
    bus_wdata_i  = 32'h0000_0BAD;
    bus_wlast_i  = 1'b1;
    repeat (4) begin
      cyc();
      chk("ce_low_rvalid", 32'(bus_rvalid_o), 32'd0);
      chk("ce_low_bvalid", 32'(bus_bvalid_o), 32'd0);
    end
    bus_ren_i    = 1'b0;
    bus_wen_i    = 1'b0;
    bus_wvalid_i = 1'b0;
    bus_wlast_i  = 1'b0;
    bus_ce_i     = 1'b1;
    cyc();
    do_read(32'h4, 0, 0, model[1]);

    // reset in the middle of a read burst
    bus_ren_i    = 1'b1;
    bus_raddr_i  = 32'h8;
    bus_rlen_i   = 4'h3;
    bus_rready_i = 1'b0;
    for (int b = 0; b < 4; b++) sbq.push_back(model[2 + b]);
    cyc();
    bus_ren_i = 1'b0;
    n = 0;
    while (!bus_rvalid_o && n < 20) begin
      cyc();
      n++;
    end
    chk("rst_burst_reached", 32'(bus_rvalid_o), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    sbq.delete();
    chk("rst_mid_rvalid", 32'(bus_rvalid_o), 32'd0);
    chk("rst_mid_rdata", bus_rdata_o, 32'h0);
    chk("rst_mid_bvalid", 32'(bus_bvalid_o), 32'd0);
    chk("rst_mid_err", 32'(protocol_err_o), 32'd0);
    cyc();
    chk("rst_stays_idle", 32'(bus_rvalid_o), 32'd0);
    do_read(32'h8, 3, 2, 32'h3000_0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
